i2s_frame_ctrl: RTL
===================

// Module: i2s_frame_ctrl
// PURPOSE
//  I2S master sequencer for the pedal audio path, clocked by mck.
//  - Derives bck and lrck from mck; these drive the external ADC.
//  - Deserialises the ADC's sdin stream into 24-bit left/right samples.
//  - Presents each stereo frame to the downstream DSP/PWM stage on a valid/ready handshake.
// PARAMETERS
//  MCK_PER_BCK   4    mck cycles per bck period; even, >=2
//  SLOT_BITS     32   bck periods per channel slot (frame = 2*SLOT_BITS)
//  SAMPLE_BITS   24   data bits per channel; MSB first; must be < SLOT_BITS
// PORTS
//  mck          in   1            system/master clock; all logic on rising edge
//  rst_n        in   1            asynchronous, active-low reset
//  en           in   1            run enable
//  sdin         in   1            serial audio data from ADC
//  bck          out  1            bit clock, registered
//  lrck         out  1            word select, registered; 0=left, 1=right
//  sample_l     out  SAMPLE_BITS  last accepted left sample (two's complement)
//  sample_r     out  SAMPLE_BITS  last accepted right sample
//  frame_valid  out  1            stereo frame available
//  frame_ready  in   1            consumer accepts frame
//  overrun      out  1            sticky: frame dropped while frame_valid pending
//  ovr_clr      in   1            clears overrun
// BEHAVIOUR
//  Reset (rst_n=0, async): all counters, bck, lrck, sample_l, sample_r, frame_valid and overrun = 0.
//  Divider
//   - Counter d runs 0..MCK_PER_BCK-1 and wraps.
//   - bck = 1 iff d >= MCK_PER_BCK/2; bck is low in the first half-period after wrap.
//  Bit counter
//   - b runs 0..2*SLOT_BITS-1.
//   - b increments on the mck edge where bck goes 1->0 (d wraps) and wraps to 0 after 2*SLOT_BITS-1.
//   - lrck is updated on that same edge: lrck = (new b >= SLOT_BITS).
//  Capture (I2S framing: 1-bck delay)
//   - sdin is sampled on the mck edge where bck goes 0->1.
//   - Slot bit s = b mod SLOT_BITS.
//   - Bits s = 1..SAMPLE_BITS shift into the left shift register (b < SLOT_BITS) or the right one; MSB first.
//   - s = 0 and s > SAMPLE_BITS are ignored; that is the ADC's padding.
//  Frame completion
//   - Completes on capture of right-channel slot bit SAMPLE_BITS (b = SLOT_BITS+SAMPLE_BITS).
//   - On the next mck edge, one of:
//     - frame_valid=0, or (frame_valid=1 & frame_ready=1): load sample_l/sample_r from the shift registers; frame_valid=1.
//     - frame_valid=1 & frame_ready=0: drop the frame, hold the outputs, set overrun.
//  Handshake
//   - Transfer occurs on a mck edge with frame_valid & frame_ready.
//   - After a transfer with no simultaneous load, frame_valid=0 on the next edge.
//   - sample_l/sample_r are stable while frame_valid=1.
//   - frame_ready while frame_valid=0 is ignored.
//  overrun
//   - Set as above; cleared by ovr_clr on the next edge.
//   - If set and clear happen on the same edge, set wins.
//  en=0
//   - Next edge: d=0, b=0, bck=0, lrck=0.
//   - Partial shift-register contents are discarded; no completion fires.
//   - frame_valid and sample outputs are held; the handshake still works.
//  en 0->1
//   - Sequencing restarts at d=0, b=0, i.e. the start of a left slot.
//   - The first frame_valid follows (2*SLOT_BITS-SLOT_BITS+SAMPLE_BITS+1) bck periods later.
//  Rates: with defaults, frame = 64 bck = 256 mck, so lrck = mck/256.
// STRUCTURE
//  Package i2s_pkg:
//   - constants SAMPLE_BITS_DEF=24, SLOT_BITS_DEF=32, MCK_PER_BCK_DEF=4;
//   - localparam widths for d and b (clog2).
//  Sub-module i2s_bck_div:
//   - d counter plus registered bck;
//   - emits one-mck strobes bck_rise/bck_fall;
//   - sync clear from en.
//  Top holds the bit counter, lrck, shift registers, output registers, handshake and overrun.
// TESTING
//  Bench drives sdin from a serialiser model keyed on DUT bck/lrck; it shifts on bck falling edges.
//  1. Reset mid-frame -> all outputs 0 immediately; after release with en=1, bck period = 4 mck, lrck period = 256 mck.
//  2. L=24'h800001, R=24'h7FFFFE, frame_ready=1 -> frame_valid pulses 1 cycle per frame with exactly those values.
//  3. L=24'hA5A5A5, R=24'h5A5A5A, frame_ready=0 for 3 frames -> frame_valid stays 1, outputs stay the first frame, overrun=1; ovr_clr -> overrun=0.
//  4. frame_ready=1 on the exact completion edge of the next frame -> old frame transferred, new frame loaded, frame_valid stays 1, overrun stays 0.
//  5. en=0 at b=40, then en=1 -> bck/lrck=0 while en=0; no frame_valid from the partial frame; the next frame captures correctly from b=0.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared constants and helpers for the I2S master sequencer.
// Default geometry matches the pedal ADC: 24-bit samples in 32-bit slots, bck = mck/4.
package i2s_pkg;

  localparam int SAMPLE_BITS_DEF = 24;
  localparam int SLOT_BITS_DEF   = 32;
  localparam int MCK_PER_BCK_DEF = 4;

  localparam int D_W_DEF = $clog2(MCK_PER_BCK_DEF);
  localparam int B_W_DEF = $clog2(2 * SLOT_BITS_DEF);

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } chan_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/i2s_bck_div.sv
// Bit-clock divider: mck phase counter, registered bck and one-mck edge strobes.
// Strobes are high in the mck cycle before the edge on which bck changes.
module i2s_bck_div
  import i2s_pkg::*;
#(
  parameter int MCK_PER_BCK = MCK_PER_BCK_DEF
) (
  input  logic mck,
  input  logic rst_n,
  input  logic en,
  output logic bck,
  output logic bck_rise,
  output logic bck_fall
);

  localparam int DW = cnt_w(MCK_PER_BCK);
  localparam logic [DW-1:0] D_LAST = DW'(MCK_PER_BCK - 1);
  localparam logic [DW-1:0] D_HALF = DW'(MCK_PER_BCK / 2);
  localparam logic [DW-1:0] D_RISE = DW'(MCK_PER_BCK / 2 - 1);

  logic [DW-1:0] d_q, d_d;
  logic          bck_q, bck_d;

  always_comb begin
    d_d = '0;
    if (en) begin
      d_d = (d_q == D_LAST) ? '0 : d_q + DW'(1);
    end
    bck_d = en && (d_d >= D_HALF);
  end

  always_ff @(posedge mck or negedge rst_n) begin
    if (!rst_n) begin
      d_q   <= '0;
      bck_q <= 1'b0;
    end else begin
      d_q   <= d_d;
      bck_q <= bck_d;
    end
  end

  assign bck      = bck_q;
  assign bck_rise = en && (d_q == D_RISE);
  assign bck_fall = en && (d_q == D_LAST);

endmodule

// File: rtl/i2s_frame_ctrl.sv
// I2S master sequencer: generates bck/lrck, deserialises sdin into 24-bit L/R
// samples and offers each stereo frame on a valid/ready handshake with sticky overrun.
module i2s_frame_ctrl
  import i2s_pkg::*;
#(
  parameter int MCK_PER_BCK = MCK_PER_BCK_DEF,
  parameter int SLOT_BITS   = SLOT_BITS_DEF,
  parameter int SAMPLE_BITS = SAMPLE_BITS_DEF
) (
  input  logic                          mck,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          sdin,
  output logic                          bck,
  output logic                          lrck,
  output logic signed [SAMPLE_BITS-1:0] sample_l,
  output logic signed [SAMPLE_BITS-1:0] sample_r,
  output logic                          frame_valid,
  input  logic                          frame_ready,
  output logic                          overrun,
  input  logic                          ovr_clr
);

  localparam int BW = cnt_w(2 * SLOT_BITS);
  localparam logic [BW-1:0] B_SLOT  = BW'(SLOT_BITS);
  localparam logic [BW-1:0] B_LAST  = BW'(2 * SLOT_BITS - 1);
  localparam logic [BW-1:0] S_FIRST = BW'(1);
  localparam logic [BW-1:0] S_LAST  = BW'(SAMPLE_BITS);

  logic bck_rise, bck_fall;

  i2s_bck_div #(
    .MCK_PER_BCK(MCK_PER_BCK)
  ) u_div (
    .mck      (mck),
    .rst_n    (rst_n),
    .en       (en),
    .bck      (bck),
    .bck_rise (bck_rise),
    .bck_fall (bck_fall)
  );

  logic [BW-1:0]                 b_q, b_d;
  logic                          lrck_q, lrck_d;
  logic [SAMPLE_BITS-1:0]        sh_l_q, sh_l_d, sh_r_q, sh_r_d;
  logic                          cmp_q, cmp_d;
  logic signed [SAMPLE_BITS-1:0] smp_l_q, smp_l_d, smp_r_q, smp_r_d;
  logic                          fv_q, fv_d;
  logic                          ovr_q, ovr_d;

  chan_e         chan;
  logic [BW-1:0] s;
  logic          s_data;
  logic          fire;
  logic          ovr_set;

  assign chan    = (b_q >= B_SLOT) ? CH_RIGHT : CH_LEFT;
  assign s       = (chan == CH_RIGHT) ? b_q - B_SLOT : b_q;
  assign s_data  = (s >= S_FIRST) && (s <= S_LAST);
  // Completion is registered, so the load happens one mck after the last bit is sampled.
  assign fire    = cmp_q && en;
  assign ovr_set = fire && fv_q && !frame_ready;

  always_comb begin
    b_d     = b_q;
    lrck_d  = lrck_q;
    sh_l_d  = sh_l_q;
    sh_r_d  = sh_r_q;
    cmp_d   = 1'b0;
    smp_l_d = smp_l_q;
    smp_r_d = smp_r_q;
    fv_d    = fv_q;
    ovr_d   = ovr_q;

    if (!en) begin
      b_d    = '0;
      lrck_d = 1'b0;
      sh_l_d = '0;
      sh_r_d = '0;
    end else begin
      if (bck_fall) begin
        b_d    = (b_q == B_LAST) ? '0 : b_q + BW'(1);
        lrck_d = (b_d >= B_SLOT);
      end
      if (bck_rise && s_data) begin
        if (chan == CH_RIGHT) sh_r_d = {sh_r_q[SAMPLE_BITS-2:0], sdin};
        else                  sh_l_d = {sh_l_q[SAMPLE_BITS-2:0], sdin};
      end
      cmp_d = bck_rise && (chan == CH_RIGHT) && (s == S_LAST);
    end

    // A load may coincide with the consumer taking the previous frame.
    if (fire && (!fv_q || frame_ready)) begin
      smp_l_d = sh_l_q;
      smp_r_d = sh_r_q;
      fv_d    = 1'b1;
    end else if (fv_q && frame_ready) begin
      fv_d = 1'b0;
    end

    if (ovr_set)      ovr_d = 1'b1;
    else if (ovr_clr) ovr_d = 1'b0;
  end

  always_ff @(posedge mck or negedge rst_n) begin
    if (!rst_n) begin
      b_q     <= '0;
      lrck_q  <= 1'b0;
      sh_l_q  <= '0;
      sh_r_q  <= '0;
      cmp_q   <= 1'b0;
      smp_l_q <= '0;
      smp_r_q <= '0;
      fv_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      b_q     <= b_d;
      lrck_q  <= lrck_d;
      sh_l_q  <= sh_l_d;
      sh_r_q  <= sh_r_d;
      cmp_q   <= cmp_d;
      smp_l_q <= smp_l_d;
      smp_r_q <= smp_r_d;
      fv_q    <= fv_d;
      ovr_q   <= ovr_d;
    end
  end

  assign lrck        = lrck_q;
  assign sample_l    = smp_l_q;
  assign sample_r    = smp_r_q;
  assign frame_valid = fv_q;
  assign overrun     = ovr_q;

endmodule
